// File: rtl/npc_pc_unit_if.sv
// Fetch-stage PC unit bus: D-stage control-flow inputs and F-stage PC outputs.
// master = driver of the redirect controls (decode/CP0 side), slave = npc_pc_unit.
interface npc_pc_unit_if;
    logic        stall;
    logic [2:0]  npc_op;
    logic        branch;
    logic [31:0] pc_d;
    logic [25:0] imm26;
    logic [31:0] ra;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] pc_f;
    logic [31:0] npc;
    logic        bd_f;
    logic        adel_f;

    modport master (
        output stall, npc_op, branch, pc_d, imm26, ra, exc_req, eret_req, epc,
        input  pc_f, npc, bd_f, adel_f
    );

    modport slave (
        input  stall, npc_op, branch, pc_d, imm26, ra, exc_req, eret_req, epc,
        output pc_f, npc, bd_f, adel_f
    );
endinterface

// File: rtl/npc_pc_unit.sv
// Fetch-stage program-counter unit for a 5-stage MIPS pipeline.
// Owns the F-stage PC, selects the next PC (exception > ERET > taken branch >
// jump > register jump > sequential), tracks the delay-slot bit of the
// instruction in F and flags fetch address errors.
// Optional macro NPC_PERF_EN adds redirect_cnt / stall_cnt performance counters.
module npc_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IMEM_BASE = 32'h0000_3000,
    parameter logic [31:0] IMEM_SIZE = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        reset,
    npc_pc_unit_if.slave bus
`ifdef NPC_PERF_EN
    ,
    output logic [31:0] redirect_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [2:0] OP_PC4 = 3'd0;
    localparam logic [2:0] OP_BR  = 3'd1;
    localparam logic [2:0] OP_J   = 3'd2;
    localparam logic [2:0] OP_JR  = 3'd3;

    // Upper fetch bound held in 33 bits so BASE + SIZE cannot wrap.
    localparam logic [32:0] IMEM_END = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};

    logic [31:0]        pc_q, pc_d;
    logic               bd_q, bd_d;
    logic               redirect;
    logic               upd_en;
    logic signed [31:0] br_off_s;
    logic [31:0]        br_target;
    logic [31:0]        pc_seq;

    assign pc_seq    = pc_q + 32'd4;
    assign br_off_s  = signed'({{14{bus.imm26[15]}}, bus.imm26[15:0], 2'b00});
    assign br_target = bus.pc_d + 32'd4 + $unsigned(br_off_s);

    // An exception overrides the stall; everything else waits for the pipe to move.
    assign upd_en = bus.exc_req | ~bus.stall;

    // Next-PC selection by priority, plus the delay-slot status of that target.
    always_comb begin
        pc_d     = pc_seq;
        bd_d     = 1'b0;
        redirect = 1'b0;
        if (bus.exc_req) begin
            pc_d     = EXC_ENTRY;
            redirect = 1'b1;
        end else if (bus.eret_req) begin
            pc_d     = bus.epc;
            redirect = 1'b1;
        end else begin
            case (bus.npc_op)
                OP_BR: begin
                    // A delay slot follows a branch whether or not it is taken.
                    bd_d = 1'b1;
                    if (bus.branch) begin
                        pc_d     = br_target;
                        redirect = 1'b1;
                    end
                end
                OP_J: begin
                    pc_d     = {bus.pc_d[31:28], bus.imm26, 2'b00};
                    bd_d     = 1'b1;
                    redirect = 1'b1;
                end
                OP_JR: begin
                    pc_d     = bus.ra;
                    bd_d     = 1'b1;
                    redirect = 1'b1;
                end
                default: begin
                    pc_d = pc_seq;
                    bd_d = 1'b0;
                end
            endcase
        end
    end

    // F-stage PC and delay-slot bit; held while stalled unless an exception hits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
            bd_q <= 1'b0;
        end else if (upd_en) begin
            pc_q <= pc_d;
            bd_q <= bd_d;
        end
    end

    assign bus.npc    = pc_d;
    assign bus.pc_f   = pc_q;
    assign bus.bd_f   = bd_q;
    // Misaligned or out-of-window targets are still fetched; they are only flagged here.
    assign bus.adel_f = (pc_q[1:0] != 2'b00) ||
                        (pc_q < IMEM_BASE) ||
                        ({1'b0, pc_q} >= IMEM_END);

`ifdef NPC_PERF_EN
    logic [31:0] redirect_cnt_q, redirect_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counter increments: redirected PC loads, and cycles held by a plain stall.
    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        if (upd_en && redirect)
            redirect_cnt_d = redirect_cnt_q + 32'd1;
        if (bus.stall && !bus.exc_req)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Performance counter registers, wrapping modulo 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_cnt_q <= 32'd0;
            stall_cnt_q    <= 32'd0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
    assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_npc_pc_unit.sv
// Self-checking bench for npc_pc_unit: a reference model computes the expected
// F-stage state for each driven cycle, pushes it to a scoreboard queue, and the
// entry is popped and compared one clock later.
module tb_npc_pc_unit;

    logic clk;
    logic reset;

    npc_pc_unit_if bus ();

`ifdef NPC_PERF_EN
    logic [31:0] redirect_cnt, stall_cnt;
    npc_pc_unit dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .redirect_cnt (redirect_cnt),
        .stall_cnt    (stall_cnt)
    );
`else
    npc_pc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        bd;
        logic        adel;
        logic [31:0] rcnt;
        logic [31:0] scnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_bad = 0;

    logic [31:0] m_pc;
    logic        m_bd;
    logic [31:0] m_rcnt;
    logic [31:0] m_scnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_adel(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc >= 32'h0000_7000);
    endfunction

    task automatic model_reset();
        m_pc   = 32'h0000_3000;
        m_bd   = 1'b0;
        m_rcnt = 32'd0;
        m_scnt = 32'd0;
        sb_q.delete();
    endtask

    // Drive one cycle of stimulus, predict, clock, then compare.
    task automatic step(input logic st, input logic exc, input logic eret,
                        input logic [2:0] op, input logic br,
                        input logic [31:0] pcd, input logic [25:0] imm,
                        input logic [31:0] ra_v, input logic [31:0] epc_v,
                        input string tag);
        logic [31:0] e_npc;
        logic        e_bd;
        logic        e_redir;
        exp_t        e;
        exp_t        got;
        bus.stall    = st;
        bus.exc_req  = exc;
        bus.eret_req = eret;
        bus.npc_op   = op;
        bus.branch   = br;
        bus.pc_d     = pcd;
        bus.imm26    = imm;
        bus.ra       = ra_v;
        bus.epc      = epc_v;
        e_bd    = 1'b0;
        e_redir = 1'b1;
        if (exc)                 e_npc = 32'h0000_4180;
        else if (eret)           e_npc = epc_v;
        else if (op == 3'd1 && br)
            e_npc = pcd + 32'd4 + {{14{imm[15]}}, imm[15:0], 2'b00};
        else if (op == 3'd2)     e_npc = {pcd[31:28], imm, 2'b00};
        else if (op == 3'd3)     e_npc = ra_v;
        else begin
            e_npc   = m_pc + 32'd4;
            e_redir = 1'b0;
        end
        if (!exc && !eret && (op == 3'd1 || op == 3'd2 || op == 3'd3)) e_bd = 1'b1;
        #1;
        chk({tag, ".npc"}, bus.npc, e_npc);
        if (exc || !st) begin
            m_pc = e_npc;
            m_bd = e_bd;
            if (e_redir) m_rcnt = m_rcnt + 32'd1;
        end
        if (st && !exc) m_scnt = m_scnt + 32'd1;
        e.pc   = m_pc;
        e.bd   = m_bd;
        e.adel = model_adel(m_pc);
        e.rcnt = m_rcnt;
        e.scnt = m_scnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk({tag, ".pc_f"}, bus.pc_f, got.pc);
        chk({tag, ".bd_f"}, {31'd0, bus.bd_f}, {31'd0, got.bd});
        chk({tag, ".adel_f"}, {31'd0, bus.adel_f}, {31'd0, got.adel});
`ifdef NPC_PERF_EN
        chk({tag, ".redirect_cnt"}, redirect_cnt, got.rcnt);
        chk({tag, ".stall_cnt"}, stall_cnt, got.scnt);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        bus.stall    = 1'b0;
        bus.exc_req  = 1'b0;
        bus.eret_req = 1'b0;
        bus.npc_op   = 3'd0;
        bus.branch   = 1'b0;
        bus.pc_d     = 32'd0;
        bus.imm26    = 26'd0;
        bus.ra       = 32'd0;
        bus.epc      = 32'd0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst.pc_f", bus.pc_f, 32'h0000_3000);
        chk("rst.bd_f", {31'd0, bus.bd_f}, 32'd0);
        chk("rst.adel_f", {31'd0, bus.adel_f}, 32'd0);
`ifdef NPC_PERF_EN
        chk("rst.redirect_cnt", redirect_cnt, 32'd0);
        chk("rst.stall_cnt", stall_cnt, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Sequential fetch
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 3'd0, 0, 32'd0, 26'd0, 32'd0, 32'd0, "seq");
        chk("seq.end", bus.pc_f, 32'h0000_300C);

        // Branch taken (backwards) and not taken
        step(0, 0, 0, 3'd1, 1, 32'h0000_3004, 26'h000FFFE, 32'd0, 32'd0, "br_t");
        chk("br_t.abs", bus.pc_f, 32'h0000_3000);
        step(0, 0, 0, 3'd1, 0, 32'h0000_3004, 26'h000FFFE, 32'd0, 32'd0, "br_nt");
        step(0, 0, 0, 3'd0, 0, 32'd0, 26'd0, 32'd0, 32'd0, "pc4");

        // Register jumps: misaligned, out of window, window edges
        step(0, 0, 0, 3'd3, 0, 32'd0, 26'd0, 32'h0000_3002, 32'd0, "jr_mis");
        step(0, 0, 0, 3'd3, 0, 32'd0, 26'd0, 32'h0000_7000, 32'd0, "jr_hi");
        step(0, 0, 0, 3'd3, 0, 32'd0, 26'd0, 32'h0000_6FFC, 32'd0, "jr_top");
        step(0, 0, 0, 3'd3, 0, 32'd0, 26'd0, 32'h0000_2FFC, 32'd0, "jr_lo");

        // Stalled jump, then release
        step(1, 0, 0, 3'd2, 0, 32'h0000_3000, 26'h0000C10, 32'd0, 32'd0, "j_st0");
        step(1, 0, 0, 3'd2, 0, 32'h0000_3000, 26'h0000C10, 32'd0, 32'd0, "j_st1");
        step(0, 0, 0, 3'd2, 0, 32'h0000_3000, 26'h0000C10, 32'd0, 32'd0, "j_go");
        chk("j_go.abs", bus.pc_f, 32'h0000_3040);

        // Exception beats stall and ERET; then ERET
        step(1, 1, 1, 3'd3, 0, 32'd0, 26'd0, 32'h0000_5000, 32'h0000_3020, "exc");
        chk("exc.abs", bus.pc_f, 32'h0000_4180);
        step(0, 0, 1, 3'd2, 0, 32'd0, 26'd0, 32'd0, 32'h0000_3020, "eret");

        // Stalled ERET redirects only once released
        step(1, 0, 1, 3'd0, 0, 32'd0, 26'd0, 32'd0, 32'h0000_3100, "eret_st");
        step(0, 0, 1, 3'd0, 0, 32'd0, 26'd0, 32'd0, 32'h0000_3100, "eret_go");

        // Wraparound and undefined op codes
        step(0, 0, 0, 3'd3, 0, 32'd0, 26'd0, 32'hFFFF_FFFC, 32'd0, "jr_top32");
        step(0, 0, 0, 3'd0, 0, 32'd0, 26'd0, 32'd0, 32'd0, "wrap");
        chk("wrap.abs", bus.pc_f, 32'h0000_0000);
        for (int k = 4; k < 8; k++)
            step(0, 0, 0, 3'(k), 1, 32'h0000_3000, 26'h0000C10, 32'h0000_5000, 32'd0, "op_undef");

        // Asynchronous reset while a JR is pending
        bus.npc_op = 3'd3;
        bus.ra     = 32'h0000_5000;
        #2;
        reset = 1'b1;
        #1;
        chk("arst.pc_f", bus.pc_f, 32'h0000_3000);
        chk("arst.bd_f", {31'd0, bus.bd_f}, 32'd0);
`ifdef NPC_PERF_EN
        chk("arst.redirect_cnt", redirect_cnt, 32'd0);
        chk("arst.stall_cnt", stall_cnt, 32'd0);
`endif
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(0, 0, 0, 3'd0, 0, 32'd0, 26'd0, 32'd0, 32'd0, "post_rst");
        chk("post_rst.abs", bus.pc_f, 32'h0000_3004);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
